// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso_stream serializer.
// PISO_PARITY_EN appends one parity beat per word when defined.
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef PISO_PARITY_EN
    localparam int PARITY_BEATS = 1;
`else
    localparam int PARITY_BEATS = 0;
`endif

    function automatic int beats_f(input int width, input int lanes, input int parity);
        return (width / lanes) + parity;
    endfunction

    function automatic int cnt_w_f(input int beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/piso_stream_if.sv
// Parallel-in and serial-out handshake bundle for piso_stream.
interface piso_stream_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 1
);
    logic [WIDTH-1:0] data_i;
    logic             valid_in;
    logic             ready_out;
    logic [LANES-1:0] data_o;
    logic             valid_out;
    logic             ready_in;
    logic             last_o;

    modport master (
        output data_i, valid_in, ready_in,
        input  ready_out, data_o, valid_out, last_o
    );

    modport slave (
        input  data_i, valid_in, ready_in,
        output ready_out, data_o, valid_out, last_o
    );
endinterface

// File: rtl/piso_hold_reg.sv
// One-entry holding buffer in front of the shifter; ready is registered
// so the upstream sees it low for exactly the cycles the buffer is full.
module piso_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_vld,
    output logic             ready
);
    logic hold_vld_s;

    // Next occupancy: load and take never coincide because ready is low while full.
    always_comb begin
        hold_vld_s = hold_vld;
        if (load) begin
            hold_vld_s = 1'b1;
        end else if (take) begin
            hold_vld_s = 1'b0;
        end else begin
            hold_vld_s = hold_vld;
        end
    end

    // Buffer storage, occupancy flag and registered ready.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            hold_data <= {WIDTH{1'b0}};
            hold_vld  <= 1'b0;
            ready     <= 1'b0;
        end else begin
            if (load) begin
                hold_data <= word;
            end
            hold_vld <= hold_vld_s;
            ready    <= !hold_vld_s;
        end
    end
endmodule

// File: rtl/piso_stream.sv
// Serializer top: shifter, beat counter, FSM and registered beat outputs.
// PISO_PARITY_EN adds a trailing parity beat carrying the XOR of the word.
module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LANES     = 1,
    parameter int LSB_FIRST = 0
) (
    input logic           clk_in,
    input logic           rst,
    piso_stream_if.slave  bus
);
    localparam int BEATS = beats_f(WIDTH, LANES, PARITY_BEATS);
    localparam int CNT_W = cnt_w_f(BEATS);

    generate
        if ((LANES < 1) || (LANES > WIDTH) || ((WIDTH % LANES) != 0)) begin : g_bad_cfg
            $error("piso_stream: WIDTH must be a multiple of LANES and 1 <= LANES <= WIDTH");
        end
    endgenerate

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shift_r, shift_s, hold_data_s, word_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [LANES-1:0] beat_s;
    logic             hold_vld_s, ready_s;
    logic             accept_s, xfer_s, last_xfer_s, direct_s, load_hold_s, take_s;
    logic             valid_s, last_s;
`ifdef PISO_PARITY_EN
    logic             par_r, par_s;
`endif

    assign accept_s    = bus.valid_in && ready_s;
    assign xfer_s      = bus.valid_out && bus.ready_in;
    assign last_xfer_s = xfer_s && (cnt_r == CNT_W'(1));
    assign direct_s    = accept_s && !hold_vld_s && ((state_r == IDLE) || last_xfer_s);
    assign load_hold_s = accept_s && !direct_s;
    assign take_s      = last_xfer_s && hold_vld_s;
    assign word_s      = direct_s ? bus.data_i : hold_data_s;
    assign bus.ready_out = ready_s;

    piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk_in    (clk_in),
        .rst       (rst),
        .load      (load_hold_s),
        .take      (take_s),
        .word      (bus.data_i),
        .hold_data (hold_data_s),
        .hold_vld  (hold_vld_s),
        .ready     (ready_s)
    );

    // Next shifter/counter/state; a new word reloads on the same edge as the last beat.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        cnt_s   = cnt_r;
`ifdef PISO_PARITY_EN
        par_s   = par_r;
`endif
        case (state_r)
            IDLE: begin
                if (direct_s) begin
                    state_s = SHIFT;
                    shift_s = word_s;
                    cnt_s   = CNT_W'(BEATS);
`ifdef PISO_PARITY_EN
                    par_s   = ^word_s;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (direct_s || take_s) begin
                    shift_s = word_s;
                    cnt_s   = CNT_W'(BEATS);
`ifdef PISO_PARITY_EN
                    par_s   = ^word_s;
`endif
                end else if (last_xfer_s) begin
                    state_s = IDLE;
                    shift_s = {WIDTH{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                end else if (xfer_s) begin
                    if (LSB_FIRST != 0) begin
                        shift_s = shift_r >> LANES;
                    end else begin
                        shift_s = shift_r << LANES;
                    end
                    cnt_s = cnt_r - CNT_W'(1);
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
                shift_s = {WIDTH{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Beat presented next cycle, derived from the next shifter contents.
    always_comb begin
        if (LSB_FIRST != 0) begin
            beat_s = shift_s[LANES-1:0];
        end else begin
            beat_s = shift_s[WIDTH-1 -: LANES];
        end
`ifdef PISO_PARITY_EN
        if (cnt_s == CNT_W'(1)) begin
            beat_s    = {LANES{1'b0}};
            beat_s[0] = par_s;
        end else begin
            beat_s = beat_s;
        end
`endif
        valid_s = (state_s == SHIFT);
        last_s  = valid_s && (cnt_s == CNT_W'(1));
    end

    // FSM state, datapath and registered output beat.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            shift_r       <= {WIDTH{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            bus.data_o    <= {LANES{1'b0}};
            bus.valid_out <= 1'b0;
            bus.last_o    <= 1'b0;
`ifdef PISO_PARITY_EN
            par_r         <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            shift_r       <= shift_s;
            cnt_r         <= cnt_s;
            bus.data_o    <= beat_s;
            bus.valid_out <= valid_s;
            bus.last_o    <= last_s;
`ifdef PISO_PARITY_EN
            par_r         <= par_s;
`endif
        end
    end
endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: three configurations (8/2 MSB, 8/2 LSB, 8/1 MSB) share stimulus.
module tb_piso_stream;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vin, rin;
    logic [7:0] din;

    always #5 clk = ~clk;

    piso_stream_if #(.WIDTH(8), .LANES(2)) ia ();
    piso_stream_if #(.WIDTH(8), .LANES(2)) ib ();
    piso_stream_if #(.WIDTH(8), .LANES(1)) ic ();

    assign ia.data_i = din;  assign ia.valid_in = vin;  assign ia.ready_in = rin;
    assign ib.data_i = din;  assign ib.valid_in = vin;  assign ib.ready_in = rin;
    assign ic.data_i = din;  assign ic.valid_in = vin;  assign ic.ready_in = rin;

    piso_stream #(.WIDTH(8), .LANES(2), .LSB_FIRST(0)) dut_a (.clk_in(clk), .rst(rst), .bus(ia));
    piso_stream #(.WIDTH(8), .LANES(2), .LSB_FIRST(1)) dut_b (.clk_in(clk), .rst(rst), .bus(ib));
    piso_stream #(.WIDTH(8), .LANES(1), .LSB_FIRST(0)) dut_c (.clk_in(clk), .rst(rst), .bus(ic));

    logic       rdy [3];
    logic       vld [3];
    logic       lst [3];
    logic [1:0] dat [3];
    assign rdy[0] = ia.ready_out;  assign vld[0] = ia.valid_out;  assign lst[0] = ia.last_o;  assign dat[0] = ia.data_o;
    assign rdy[1] = ib.ready_out;  assign vld[1] = ib.valid_out;  assign lst[1] = ib.last_o;  assign dat[1] = ib.data_o;
    assign rdy[2] = ic.ready_out;  assign vld[2] = ic.valid_out;  assign lst[2] = ic.last_o;  assign dat[2] = {1'b0, ic.data_o};

    int checks = 0;
    int failures = 0;
    int acc_w [3][$];
    int got [3][$];
    int inv_obs [3][$];
    int inv_exp [3][$];
    int n_acc [3];
    int beats_done [3];
    bit sampling = 1'b0;

    function automatic int nb(input int d);
        return ((d == 2) ? 8 : 4) + PAR;
    endfunction

    // Expected beat k of a word: data in bits [7:0], last flag in bit 8.
    function automatic int exp_beat(input int d, input int word, input int k);
        int lanes, nd, v, mask;
        logic [7:0] w;
        w     = word[7:0];
        lanes = (d == 2) ? 1 : 2;
        nd    = 8 / lanes;
        mask  = (1 << lanes) - 1;
        if (k >= nd) return int'(^w) | 256;
        if (d == 1) v = (word >> (lanes * k)) & mask;
        else        v = (word >> (8 - lanes * (k + 1))) & mask;
        if ((k == nd - 1) && (PAR == 0)) v = v | 256;
        return v;
    endfunction

    task automatic clear_logs();
        for (int d = 0; d < 3; d++) begin
            acc_w[d].delete(); got[d].delete(); inv_obs[d].delete(); inv_exp[d].delete();
            n_acc[d] = 0; beats_done[d] = 0;
        end
    endtask

    // Log handshakes seen before the coming edge; words in flight give expected ready/valid.
    task automatic sample();
        int outst;
        if (sampling) begin
            for (int d = 0; d < 3; d++) begin
                outst = n_acc[d] - beats_done[d] / nb(d);
                inv_obs[d].push_back((int'(rdy[d]) << 1) | int'(vld[d]));
                inv_exp[d].push_back((int'(outst < 2) << 1) | int'(outst > 0));
                if (vld[d] && rin) begin
                    got[d].push_back(int'(dat[d]) | (int'(lst[d]) << 8));
                    beats_done[d]++;
                end
                if (vin && rdy[d]) begin
                    acc_w[d].push_back(int'(din));
                    n_acc[d]++;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vin = 1'b0; din = 8'h00; rin = 1'b0;
        #1 rst = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({rdy[d], vld[d], lst[d], dat[d]} !== 5'b0) begin
                failures++;
                $display("FAIL reset_outputs d=%0d got=%b expected=00000", d, {rdy[d], vld[d], lst[d], dat[d]});
            end
        end
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rdy[d] !== 1'b0) begin
                failures++;
                $display("FAIL ready_before_edge d=%0d got=%b expected=0", d, rdy[d]);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({rdy[d], vld[d]} !== 2'b10) begin
                failures++;
                $display("FAIL ready_after_release d=%0d got=%b expected=10", d, {rdy[d], vld[d]});
            end
        end
        clear_logs();
        sampling = 1'b1;
    endtask

    task automatic test_single_word();
        int e;
        clear_logs();
        rin = 1'b1; vin = 1'b1; din = 8'hB4;
        tick();
        vin = 1'b0;
        repeat (14) tick();
        checks++;
        if (got[0].size() < 1 || got[0][0] !== 2 || got[1].size() < 1 || got[1][0] !== 0) begin
            failures++;
            $display("FAIL first_beat_order msb=%0d lsb=%0d expected msb=2 lsb=0",
                     (got[0].size() > 0) ? got[0][0] : -1, (got[1].size() > 0) ? got[1][0] : -1);
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (got[d].size() != nb(d)) begin
                failures++;
                $display("FAIL single_count d=%0d got=%0d expected=%0d", d, got[d].size(), nb(d));
            end
            for (int i = 0; i < got[d].size() && i < nb(d); i++) begin
                e = exp_beat(d, 'hB4, i);
                checks++;
                if (got[d][i] !== e) begin
                    failures++;
                    $display("FAIL single_beat d=%0d i=%0d got=%h expected=%h", d, i, got[d][i], e);
                end
            end
            for (int i = 0; i < inv_obs[d].size(); i++) begin
                checks++;
                if (inv_obs[d][i] !== inv_exp[d][i]) begin
                    failures++;
                    $display("FAIL single_rdy_vld d=%0d cyc=%0d got=%b expected=%b", d, i, inv_obs[d][i][1:0], inv_exp[d][i][1:0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int e, nv;
        clear_logs();
        rin = 1'b1; vin = 1'b1; din = 8'hB4;
        tick();
        din = 8'h5A;
        tick();
        vin = 1'b0;
        repeat (24) tick();
        for (int d = 0; d < 3; d++) begin
            nv = 0;
            foreach (inv_obs[d][i]) nv += inv_obs[d][i] & 1;
            checks++;
            if (nv != 2 * nb(d) || acc_w[d].size() != 2) begin
                failures++;
                $display("FAIL b2b_valid_cycles d=%0d got=%0d words=%0d expected=%0d words=2", d, nv, acc_w[d].size(), 2 * nb(d));
            end
            for (int i = 0; i < got[d].size() && i / nb(d) < acc_w[d].size(); i++) begin
                e = exp_beat(d, acc_w[d][i / nb(d)], i % nb(d));
                checks++;
                if (got[d][i] !== e) begin
                    failures++;
                    $display("FAIL b2b_beat d=%0d i=%0d got=%h expected=%h", d, i, got[d][i], e);
                end
            end
            for (int i = 0; i < inv_obs[d].size(); i++) begin
                checks++;
                if (inv_obs[d][i] !== inv_exp[d][i]) begin
                    failures++;
                    $display("FAIL b2b_rdy_vld d=%0d cyc=%0d got=%b expected=%b", d, i, inv_obs[d][i][1:0], inv_exp[d][i][1:0]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [1:0] d0;
        logic       l0;
        int         e;
        clear_logs();
        rin = 1'b1; vin = 1'b1; din = 8'h81;
        tick();
        vin = 1'b0;
        repeat (2) tick();
        rin = 1'b0;
        d0 = dat[2]; l0 = lst[2];
        repeat (3) begin
            tick();
            checks++;
            if ({vld[2], lst[2], dat[2]} !== {1'b1, l0, d0}) begin
                failures++;
                $display("FAIL stall_stable got=%b expected=%b", {vld[2], lst[2], dat[2]}, {1'b1, l0, d0});
            end
        end
        rin = 1'b1;
        repeat (14) tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (got[d].size() != nb(d)) begin
                failures++;
                $display("FAIL stall_count d=%0d got=%0d expected=%0d", d, got[d].size(), nb(d));
            end
        end
        for (int i = 0; i < got[2].size() && i < nb(2); i++) begin
            e = exp_beat(2, 'h81, i);
            checks++;
            if (got[2][i] !== e) begin
                failures++;
                $display("FAIL stall_beat i=%0d got=%h expected=%h", i, got[2][i], e);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        clear_logs();
        rin = 1'b1; vin = 1'b1; din = 8'hB4;
        tick();
        din = 8'h5A;
        tick();
        vin = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({rdy[d], vld[d], lst[d], dat[d]} !== 5'b0) begin
                failures++;
                $display("FAIL midreset_outputs d=%0d got=%b expected=00000", d, {rdy[d], vld[d], lst[d], dat[d]});
            end
        end
        sampling = 1'b0;
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        clear_logs();
        sampling = 1'b1;
        repeat (12) tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (got[d].size() != 0 || rdy[d] !== 1'b1 || vld[d] !== 1'b0) begin
                failures++;
                $display("FAIL midreset_no_resume d=%0d beats=%0d rdy=%b vld=%b expected beats=0 rdy=1 vld=0", d, got[d].size(), rdy[d], vld[d]);
            end
        end
    endtask

    task automatic test_random();
        int e;
        clear_logs();
        for (int c = 0; c < 400; c++) begin
            vin = 1'($urandom_range(0, 1));
            din = 8'($urandom);
            rin = ($urandom_range(0, 3) != 0);
            tick();
        end
        vin = 1'b0; rin = 1'b1;
        repeat (30) tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (got[d].size() != acc_w[d].size() * nb(d) || acc_w[d].size() == 0) begin
                failures++;
                $display("FAIL rand_count d=%0d got=%0d words=%0d expected=%0d", d, got[d].size(), acc_w[d].size(), acc_w[d].size() * nb(d));
            end
            for (int i = 0; i < got[d].size() && i / nb(d) < acc_w[d].size(); i++) begin
                e = exp_beat(d, acc_w[d][i / nb(d)], i % nb(d));
                checks++;
                if (got[d][i] !== e) begin
                    failures++;
                    $display("FAIL rand_beat d=%0d i=%0d got=%h expected=%h", d, i, got[d][i], e);
                end
            end
            for (int i = 0; i < inv_obs[d].size(); i++) begin
                checks++;
                if (inv_obs[d][i] !== inv_exp[d][i]) begin
                    failures++;
                    $display("FAIL rand_rdy_vld d=%0d cyc=%0d got=%b expected=%b", d, i, inv_obs[d][i][1:0], inv_exp[d][i][1:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out serializer with valid/ready handshakes on both sides, single clock domain.
- Accepts a WIDTH-bit word from upstream and emits it as WIDTH/LANES beats of LANES bits each, MSB-first or LSB-first.
- A one-word holding register allows the next word to be accepted while the current one shifts out, so back-to-back words stream without bubbles.
- Next generation of the register-family PISO; sits between parallel producers and narrow serial links.

Parameters:
- WIDTH, 8: input word width. Must be a multiple of LANES; elaboration-time error otherwise.
- LANES, 1: output bits per beat. 1 ≤ LANES ≤ WIDTH.
- LSB_FIRST, 0: 0 sends the MSB-side lane group first; 1 sends the LSB-side lane group first.

Ports:
- clk_in  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_i  input  WIDTH  parallel input word.
- valid_in  input  1  upstream word valid.
- ready_out  output  1  block can accept a word this cycle.
- data_o  output  LANES  current serial beat.
- valid_out  output  1  data_o holds a valid beat.
- ready_in  input  1  downstream accepts the beat this cycle.
- last_o  output  1  current beat is the final beat of its word; qualified by valid_out.

Behaviour:
- BEATS = WIDTH/LANES (+1 when PISO_PARITY_EN is defined). Beat counter width is $clog2(BEATS+1).
- Reset (async assert, state held while rst=1): shift register, hold register, hold_vld, counter, data_o, valid_out and last_o are all 0. ready_out is 0 while rst=1 and goes to 1 on the first clock edge after release.
- Input handshake:
  - Accept = valid_in && ready_out.
  - ready_out = !hold_vld, registered.
  - data_i is sampled only on an accept edge.
- Output handshake:
  - Beat transfer = valid_out && ready_in.
  - data_o, last_o and valid_out hold stable while valid_out && !ready_in. No beat is dropped or repeated.
- States:
  - IDLE: shifter empty, valid_out=0.
  - SHIFT: shifter holds the active word, valid_out=1.
- Load rules on an accept edge:
  - Shifter empty (IDLE), or its last beat transfers on the same edge, and hold empty: the word loads straight into the shifter. The first beat is on data_o the next cycle (latency 1).
  - Otherwise: the word goes into hold and hold_vld is set.
- Last-beat transfer:
  - hold_vld=1: the hold word moves into the shifter on the same edge, hold_vld clears, and ready_out returns to 1. No idle cycle occurs.
  - hold empty and no accept on that edge: return to IDLE; valid_out=0 next cycle.
- Shifting:
  - LSB_FIRST=0: data_o = shifter[WIDTH-1 -: LANES], and the shifter shifts left by LANES on each transfer.
  - LSB_FIRST=1: data_o = shifter[LANES-1:0], and the shifter shifts right by LANES.
  - Vacated bits fill with 0.
- Counter loads BEATS on word load and decrements on each transfer. last_o=1 when counter==1.
- Simultaneous accept and last transfer with hold full is impossible, because ready_out=0 while hold is full.
- Asserting rst mid-word discards both the shifter and hold contents; no partial word resumes.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - One extra beat is appended after the data beats.
  - data_o = {(LANES-1)'b0, p}, where p = ^word, the XOR of all WIDTH bits latched at load.
  - last_o is asserted on the parity beat only.
- Undefined:
  - No parity logic or storage.
  - last_o is asserted on the final data beat.

Decomposition:
- Package piso_pkg:
  - State enum (IDLE, SHIFT).
  - Function beats_f(width, lanes, parity) returning the beat count.
  - Function cnt_w_f returning the counter width.
- One natural sub-module, piso_hold_reg: the one-entry holding buffer with hold_vld and ready_out generation.
- The top level keeps the shifter, counter, FSM and parity.

Test Plan:
- WIDTH=8, LANES=2, LSB_FIRST=0, send 0xB4 with ready_in=1: data_o = 10, 11, 01, 00; last_o on the 4th beat; valid_out drops the next cycle.
- Same word with LSB_FIRST=1: data_o = 00, 01, 11, 10.
- Back-to-back 0xB4 then 0x5A with continuous valid_in: 8 consecutive valid beats, no bubble. ready_out is low for exactly the cycles hold is full.
- Hold ready_in=0 for 3 cycles mid-word (WIDTH=8, LANES=1, 0x81): data_o and last_o stay stable; resuming yields 1,0,0,0,0,0,0,1 with no repeated or lost beat.
- Assert rst during the 2nd beat with hold full: all outputs go to 0 asynchronously, and the old words never appear after release.
- PISO_PARITY_EN, WIDTH=8, LANES=1:
  - 0xB4 → 8 data beats, then a parity beat of 0 with last_o=1.
  - 0xB5 → the parity beat is 1.
